// File: rtl/crypto_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : crypto_job_sequencer_if
// Brief    : Job stream, cipher-core and result signals of the job sequencer.
// Revision : 1.0
// ============================================================================
interface crypto_job_sequencer_if #(
    parameter int BLOCK_W    = 128,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [BLOCK_W-1:0]   in_data;
    logic                 key_load;
    logic [BLOCK_W-1:0]   key_in;
    logic [BLOCK_W-1:0]   eng_plaintext;
    logic [BLOCK_W-1:0]   eng_key;
    logic                 eng_start;
    logic                 eng_done;
    logic [BLOCK_W-1:0]   eng_ciphertext;
    logic                 out_valid;
    logic                 out_ready;
    logic [BLOCK_W-1:0]   out_data;
    logic                 timeout_err;
    logic                 busy;
    logic [c_CNT_W-1:0]   fifo_count;

    // Sequencer side
    modport slave (
        input  in_valid, in_data, key_load, key_in, eng_done, eng_ciphertext, out_ready,
        output in_ready, eng_plaintext, eng_key, eng_start, out_valid, out_data,
               timeout_err, busy, fifo_count
    );

    // Environment side (job source, cipher core, result sink)
    modport master (
        output in_valid, in_data, key_load, key_in, eng_done, eng_ciphertext, out_ready,
        input  in_ready, eng_plaintext, eng_key, eng_start, out_valid, out_data,
               timeout_err, busy, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/crypto_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : crypto_job_sequencer
// Brief    : Queues plaintext jobs and issues them one at a time to the cipher
//            core with a per-job key snapshot; captures the ciphertext into a
//            valid/ready register and abandons jobs whose core never finishes.
// Revision : 1.0
// ============================================================================
module crypto_job_sequencer #(
    parameter int BLOCK_W    = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    crypto_job_sequencer_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [BLOCK_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [BLOCK_W-1:0]   r_key;
    logic [BLOCK_W-1:0]   r_eng_pt;
    logic [BLOCK_W-1:0]   r_eng_key;
    logic [c_TMO_W-1:0]   r_wait_cnt;
    logic                 r_out_valid;
    logic [BLOCK_W-1:0]   r_out_data;
    logic                 r_timeout_err;

    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_out_accept;

    assign w_in_ready   = (r_count < c_FIFO_FULL);
    assign w_push       = bus.in_valid && w_in_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_done       = (r_state == S_WAIT) && bus.eng_done;
    // A done on the terminal-count cycle takes priority over the timeout.
    assign w_timeout    = (r_state == S_WAIT) && !bus.eng_done && (r_wait_cnt == c_TMO_LAST);
    assign w_out_accept = (r_state == S_HOLD) && r_out_valid && bus.out_ready;

    // ------------------------------------------------------------------------
    // Job FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    w_state_nxt = S_HOLD;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_out_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Job FIFO (storage is not reset; occupancy and pointers are)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Key register and per-job launch registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key <= '0;
        end else if (bus.key_load) begin
            r_key <= bus.key_in;
        end
    end

    // The snapshot reads r_key before this edge, so a simultaneous key_load
    // only affects the following job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eng_pt   <= '0;
            r_eng_key  <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_eng_pt   <= r_mem[r_rd_ptr];
                r_eng_key  <= r_key;
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT) && !bus.eng_done) begin
                r_wait_cnt <= r_wait_cnt + c_TMO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result register and sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.eng_ciphertext;
            end else if (w_out_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.fifo_count    = r_count;
    assign bus.eng_plaintext = r_eng_pt;
    assign bus.eng_key       = r_eng_key;
    assign bus.eng_start     = (r_state == S_START);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.timeout_err   = r_timeout_err;

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    a_start_single_cycle: assert property (@(posedge clk) disable iff (rst)
        bus.eng_start |=> !bus.eng_start);

    a_count_bounded: assert property (@(posedge clk) disable iff (rst)
        r_count <= c_FIFO_FULL);

    a_result_held: assert property (@(posedge clk) disable iff (rst)
        (r_out_valid && !bus.out_ready) |=> (r_out_valid && $stable(r_out_data)));

endmodule
`default_nettype wire

// File: tb/tb_crypto_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_crypto_job_sequencer
// Brief    : Directed and randomized bench with a queue-based reference model
//            of the job sequencer and a simple fixed-latency cipher core.
// Revision : 1.0
// ============================================================================
module tb_crypto_job_sequencer;
    localparam int BLOCK_W    = 128;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 32;

    typedef logic [BLOCK_W-1:0] blk_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    crypto_job_sequencer_if #(.BLOCK_W(BLOCK_W), .FIFO_DEPTH(FIFO_DEPTH)) intf ();

    crypto_job_sequencer #(
        .BLOCK_W    (BLOCK_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input blk_t act, input blk_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Cipher core model: ciphertext = plaintext ^ key, done is sampled by the
    // sequencer core_lat+1 edges after it samples eng_start.
    // ------------------------------------------------------------------------
    logic core_en   = 1'b1;
    int   core_lat  = 8;
    int   cd        = 0;
    logic core_done = 1'b0;
    logic inj_done  = 1'b0;
    blk_t core_ct   = '0;

    assign intf.eng_done       = core_done | inj_done;
    assign intf.eng_ciphertext = core_ct;

    always @(negedge clk) begin
        if (rst) begin
            cd        = 0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (cd != 0) begin
                core_done = (cd == 1);
                cd--;
            end
            if (intf.eng_start && core_en) begin
                cd      = core_lat + 1;
                core_ct = intf.eng_plaintext ^ intf.eng_key;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model / scoreboard, evaluated between clock edges.
    // push_q: accepted plaintexts not yet issued; exp_q: results owed.
    // ------------------------------------------------------------------------
    blk_t push_q[$];
    blk_t exp_q[$];
    blk_t k_reg     = '0;
    blk_t k_prev    = '0;
    logic inflight  = 1'b0;
    logic hold_prev = 1'b0;
    int   n_starts  = 0;

    always @(negedge clk) begin
        blk_t pt;
        if (rst) begin
            push_q.delete();
            exp_q.delete();
            k_reg     = '0;
            k_prev    = '0;
            inflight  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (intf.eng_start) begin
                n_starts++;
                check_eq("start_while_in_flight", blk_t'(inflight), '0);
                check_eq("start_has_job", blk_t'(push_q.size() != 0), blk_t'(1));
                if (push_q.size() != 0) begin
                    pt = push_q.pop_front();
                    check_eq("eng_plaintext", intf.eng_plaintext, pt);
                    check_eq("eng_key", intf.eng_key, k_prev);
                    if (core_en) exp_q.push_back(pt ^ k_prev);
                end
                inflight = 1'b1;
            end
            if (hold_prev) check_eq("out_valid_held", blk_t'(intf.out_valid), blk_t'(1));
            if (intf.out_valid && intf.out_ready) begin
                check_eq("result_owed", blk_t'(exp_q.size() != 0), blk_t'(1));
                if (exp_q.size() != 0) check_eq("out_data", intf.out_data, exp_q.pop_front());
            end
            hold_prev = intf.out_valid && !intf.out_ready;
            if (!intf.busy) inflight = 1'b0;
            check_eq("fifo_count", blk_t'(intf.fifo_count), blk_t'(push_q.size()));
            check_eq("in_ready", blk_t'(intf.in_ready), blk_t'(push_q.size() < FIFO_DEPTH));
            if (intf.in_valid && push_q.size() < FIFO_DEPTH) push_q.push_back(intf.in_data);
            k_prev = k_reg;
            if (intf.key_load) k_reg = intf.key_in;
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input blk_t d);
        intf.in_valid = 1'b1;
        intf.in_data  = d;
        tick();
        intf.in_valid = 1'b0;
    endtask

    function automatic blk_t rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_idle(input string tag, input int max);
        int w = 0;
        while ((intf.busy || intf.fifo_count != 0 || exp_q.size() != 0) && w < max) begin
            @(negedge clk);
            w++;
        end
        check_eq(tag, blk_t'(w < max), blk_t'(1));
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_fifo_count"},    blk_t'(intf.fifo_count),  '0);
        check_eq({tag, "_in_ready"},      blk_t'(intf.in_ready),    blk_t'(1));
        check_eq({tag, "_eng_plaintext"}, intf.eng_plaintext,       '0);
        check_eq({tag, "_eng_key"},       intf.eng_key,             '0);
        check_eq({tag, "_eng_start"},     blk_t'(intf.eng_start),   '0);
        check_eq({tag, "_out_valid"},     blk_t'(intf.out_valid),   '0);
        check_eq({tag, "_out_data"},      intf.out_data,            '0);
        check_eq({tag, "_timeout_err"},   blk_t'(intf.timeout_err), '0);
        check_eq({tag, "_busy"},          blk_t'(intf.busy),        '0);
    endtask

    // Global guard against a hung run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        blk_t key_a, pt_a, new_key, od;
        int   t, w, s0, n_s, first_start, first_ov;

        intf.in_valid  = 1'b0;
        intf.in_data   = '0;
        intf.key_load  = 1'b0;
        intf.key_in    = '0;
        intf.out_ready = 1'b1;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // ---- Single job with 8-cycle core, latency from push edge ----
        key_a = 128'h000102030405060708090A0B0C0D0E0F;
        pt_a  = {16{8'h11}};
        intf.key_load = 1'b1;
        intf.key_in   = key_a;
        tick();
        intf.key_load = 1'b0;
        push(pt_a);
        n_s = 0; first_start = -1; first_ov = -1; od = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (intf.eng_start) begin
                n_s++;
                if (first_start < 0) first_start = c;
            end
            if (intf.out_valid && first_ov < 0) begin
                first_ov = c;
                od = intf.out_data;
            end
        end
        check_eq("single_start_pulses", blk_t'(n_s), blk_t'(1));
        check_eq("single_start_edge", blk_t'(first_start), blk_t'(1));
        check_eq("single_out_valid_edge", blk_t'(first_ov), blk_t'(11));
        check_eq("single_out_data", od, pt_a ^ key_a);
        wait_idle("single_drain", 50);

        // ---- Done on the timeout terminal-count cycle wins ----
        core_lat = TIMEOUT - 1;
        push(rand_blk());
        first_ov = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (intf.out_valid && first_ov < 0) first_ov = c;
        end
        check_eq("terminal_done_out_valid_edge", blk_t'(first_ov), blk_t'(TIMEOUT + 2));
        check_eq("terminal_done_no_error", blk_t'(intf.timeout_err), '0);
        core_lat = 8;
        wait_idle("terminal_drain", 50);

        // ---- Back-to-back: one in flight plus FIFO_DEPTH queued ----
        s0 = n_starts;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) push(rand_blk());
        @(negedge clk);
        check_eq("b2b_full_in_ready", blk_t'(intf.in_ready), '0);
        check_eq("b2b_full_count", blk_t'(intf.fifo_count), blk_t'(FIFO_DEPTH));
        wait_idle("b2b_drain", 400);
        check_eq("b2b_start_count", blk_t'(n_starts - s0), blk_t'(FIFO_DEPTH + 1));
        check_eq("b2b_count_zero", blk_t'(intf.fifo_count), '0);

        // ---- Backpressure: result held, no new start ----
        intf.out_ready = 1'b0;
        s0 = n_starts;
        push(rand_blk());
        push(rand_blk());
        for (w = 0; w < 60; w++) begin
            @(negedge clk);
            if (intf.out_valid) break;
        end
        check_eq("bp_result_arrived", blk_t'(w < 60), blk_t'(1));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("bp_out_valid", blk_t'(intf.out_valid), blk_t'(1));
            if (exp_q.size() != 0) check_eq("bp_out_data", intf.out_data, exp_q[0]);
        end
        check_eq("bp_single_start", blk_t'(n_starts - s0), blk_t'(1));
        tick();
        intf.out_ready = 1'b1;
        wait_idle("bp_drain", 100);
        check_eq("bp_both_started", blk_t'(n_starts - s0), blk_t'(2));

        // ---- Key load on the same edge as a pop ----
        new_key = rand_blk();
        push(rand_blk());
        intf.key_load = 1'b1;
        intf.key_in   = new_key;
        tick();
        intf.key_load = 1'b0;
        intf.in_valid = 1'b1;
        intf.in_data  = rand_blk();
        @(negedge clk);
        check_eq("race_first_start", blk_t'(intf.eng_start), blk_t'(1));
        check_eq("race_first_old_key", intf.eng_key, key_a);
        tick();
        intf.in_valid = 1'b0;
        for (w = 0; w < 100; w++) begin
            @(negedge clk);
            if (intf.eng_start) break;
        end
        check_eq("race_second_started", blk_t'(w < 100), blk_t'(1));
        check_eq("race_second_new_key", intf.eng_key, new_key);
        tick();
        wait_idle("race_drain", 100);

        // ---- Timeout with a core that never answers ----
        core_en = 1'b0;
        push(rand_blk());
        push(rand_blk());
        for (w = 0; w < 10; w++) begin
            @(negedge clk);
            if (intf.eng_start) break;
        end
        check_eq("tmo_first_started", blk_t'(w < 10), blk_t'(1));
        for (t = 0; t < TIMEOUT + 8; t++) begin
            @(negedge clk);
            if (intf.timeout_err) break;
        end
        check_eq("tmo_error_edge", blk_t'(t), blk_t'(TIMEOUT));
        check_eq("tmo_back_to_idle", blk_t'(intf.busy), '0);
        check_eq("tmo_no_result", blk_t'(intf.out_valid), '0);
        @(negedge clk);
        check_eq("tmo_next_job_start", blk_t'(intf.eng_start), blk_t'(1));
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        @(negedge clk);
        check_eq("tmo_done_in_start_ignored", blk_t'(intf.out_valid), '0);
        check_eq("tmo_second_waiting", blk_t'(intf.busy), blk_t'(1));
        for (w = 0; w < TIMEOUT + 8; w++) begin
            @(negedge clk);
            if (!intf.busy) break;
        end
        check_eq("tmo_second_abandoned", blk_t'(w < TIMEOUT + 8), blk_t'(1));
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        @(negedge clk);
        check_eq("tmo_late_done_no_valid", blk_t'(intf.out_valid), '0);
        check_eq("tmo_late_done_idle", blk_t'(intf.busy), '0);
        check_eq("tmo_error_sticky", blk_t'(intf.timeout_err), blk_t'(1));
        tick();

        // ---- Asynchronous reset during WAIT with two jobs queued ----
        push(rand_blk());
        push(rand_blk());
        push(rand_blk());
        #2;
        check_eq("rst_pre_busy", blk_t'(intf.busy), blk_t'(1));
        check_eq("rst_pre_count", blk_t'(intf.fifo_count), blk_t'(2));
        rst = 1'b1;
        #1;
        check_reset_values("rst_wait");
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("rst_no_start", blk_t'(intf.eng_start), '0);
            check_eq("rst_stays_idle", blk_t'(intf.busy), '0);
        end
        tick();
        core_en = 1'b1;
        push(rand_blk());
        wait_idle("rst_recovery", 60);

        // ---- Randomized traffic ----
        for (int c = 0; c < 300; c++) begin
            intf.in_valid  = ($urandom_range(0, 1) == 1);
            intf.in_data   = rand_blk();
            intf.key_load  = ($urandom_range(0, 4) == 0);
            intf.key_in    = rand_blk();
            intf.out_ready = ($urandom_range(0, 9) < 7);
            core_lat       = $urandom_range(1, 20);
            tick();
        end
        intf.in_valid  = 1'b0;
        intf.key_load  = 1'b0;
        intf.out_ready = 1'b1;
        wait_idle("random_drain", 2000);
        check_eq("random_no_owed_results", blk_t'(exp_q.size()), '0);
        check_eq("random_no_error", blk_t'(intf.timeout_err), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
